// File: rtl/bbp_rx_pkg.sv
// Shared types and defaults for the layer-1 receive chain.
// Frame buffer beat format, write-side states and sizing.
package bbp_rx_pkg;

  localparam int RXFB_DEPTH_LOG2      = 9;
  localparam int RXFB_MAX_FRAME_WORDS = 256;
  localparam int RXFB_CNT_W           = 16;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } rxfb_beat_t;

  typedef enum logic {
    ACCEPT,
    DROP
  } rxfb_state_t;

endpackage

// File: rtl/rx_frame_buffer_if.sv
// 64-bit AXI-stream link between receive chain blocks.
// master drives the beat, slave returns ready.
interface rx_frame_buffer_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic        tlast;

  modport master (
    output tvalid, tdata, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tlast,
    output tready
  );
endinterface

// File: rtl/rx_frame_buffer_ram.sv
// Simple dual-port beat store with registered read port.
// The array carries no reset.
module rx_frame_buffer_ram
  import bbp_rx_pkg::*;
#(
  parameter int DEPTH_LOG2 = RXFB_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  wrEn,
  input  logic [DEPTH_LOG2-1:0] wrAddr,
  input  rxfb_beat_t            wrBeat,
  input  logic                  rdEn,
  input  logic [DEPTH_LOG2-1:0] rdAddr,
  output rxfb_beat_t            rdBeat
);

  rxfb_beat_t mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrBeat;
    if (rdEn) rdBeat <= mem[rdAddr];
  end

endmodule

// File: rtl/rx_frame_buffer.sv
// Store-and-forward frame buffer: only complete frames reach the host side.
// Input never stalls; frames that overflow or exceed the length limit are dropped whole.
module rx_frame_buffer
  import bbp_rx_pkg::*;
#(
  parameter int DEPTH_LOG2      = RXFB_DEPTH_LOG2,
  parameter int MAX_FRAME_WORDS = RXFB_MAX_FRAME_WORDS,
  parameter int CNT_W           = RXFB_CNT_W
) (
  input  logic                 clk,
  input  logic                 aresetn,
  rx_frame_buffer_if.slave     s_axis_input,
  rx_frame_buffer_if.master    m_axis_output,
  output logic [CNT_W-1:0]     frame_ok_cnt,
  output logic [CNT_W-1:0]     frame_drop_cnt,
  output logic [DEPTH_LOG2:0]  level
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam int LW = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  function automatic logic [CNT_W-1:0] satInc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  rxfb_state_t       state, stateNext;
  logic [PW-1:0]     wrPtr, wrPtrNext;
  logic [PW-1:0]     commitPtr, commitPtrNext;
  logic [PW-1:0]     fetchPtr, rdPtr;
  logic [LW-1:0]     frameLen, frameLenNext;
  logic [CNT_W-1:0]  okCnt, okCntNext;
  logic [CNT_W-1:0]  dropCnt, dropCntNext;
  logic              inBeat, full, wrEn;

  assign s_axis_input.tready = aresetn;
  assign inBeat = s_axis_input.tvalid & s_axis_input.tready;
  assign full   = (wrPtr - rdPtr) == DEPTH;

  always_comb begin
    stateNext     = state;
    wrPtrNext     = wrPtr;
    commitPtrNext = commitPtr;
    frameLenNext  = frameLen;
    okCntNext     = okCnt;
    dropCntNext   = dropCnt;
    wrEn          = 1'b0;
    unique case (state)
      ACCEPT: begin
        if (inBeat) begin
          if (full || frameLen == LW'(MAX_FRAME_WORDS)) begin
            wrPtrNext    = commitPtr;
            frameLenNext = '0;
            dropCntNext  = satInc(dropCnt);
            stateNext    = s_axis_input.tlast ? ACCEPT : DROP;
          end else begin
            wrEn      = 1'b1;
            wrPtrNext = wrPtr + 1'b1;
            if (s_axis_input.tlast) begin
              commitPtrNext = wrPtr + 1'b1;
              frameLenNext  = '0;
              okCntNext     = satInc(okCnt);
            end else begin
              frameLenNext = frameLen + 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (inBeat && s_axis_input.tlast) begin
          stateNext    = ACCEPT;
          frameLenNext = '0;
        end
      end
      default: stateNext = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ACCEPT;
      wrPtr     <= '0;
      commitPtr <= '0;
      frameLen  <= '0;
      okCnt     <= '0;
      dropCnt   <= '0;
    end else begin
      state     <= stateNext;
      wrPtr     <= wrPtrNext;
      commitPtr <= commitPtrNext;
      frameLen  <= frameLenNext;
      okCnt     <= okCntNext;
      dropCnt   <= dropCntNext;
    end
  end

  assign frame_ok_cnt   = okCnt;
  assign frame_drop_cnt = dropCnt;

  // Read side: RAM stage -> output reg -> skid; fetch only when both
  // beats that could land next cycle still have a slot.
  rxfb_beat_t wrBeat, ramBeat, outBeat, skidBeat;
  logic       ramValid, outValid, skidValid;
  logic       avail, rdEn, pop;
  logic [1:0] occ;

  assign wrBeat = '{data: s_axis_input.tdata, last: s_axis_input.tlast};
  assign avail  = fetchPtr != commitPtr;
  assign pop    = outValid & m_axis_output.tready;
  assign occ    = 2'(outValid) + 2'(skidValid)
                + 2'(ramValid) - 2'(pop);
  assign rdEn   = avail && (occ <= 2'd1);

  rx_frame_buffer_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk    (clk),
    .wrEn   (wrEn),
    .wrAddr (wrPtr[DEPTH_LOG2-1:0]),
    .wrBeat (wrBeat),
    .rdEn   (rdEn),
    .rdAddr (fetchPtr[DEPTH_LOG2-1:0]),
    .rdBeat (ramBeat)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      fetchPtr  <= '0;
      rdPtr     <= '0;
      ramValid  <= 1'b0;
      outValid  <= 1'b0;
      outBeat   <= '0;
      skidValid <= 1'b0;
      skidBeat  <= '0;
      level     <= '0;
    end else begin
      fetchPtr <= fetchPtr + PW'(rdEn);
      rdPtr    <= rdPtr + PW'(pop);
      ramValid <= rdEn;
      if (pop || !outValid) begin
        if (skidValid) begin
          outValid  <= 1'b1;
          outBeat   <= skidBeat;
          skidValid <= ramValid;
          if (ramValid) skidBeat <= ramBeat;
        end else begin
          outValid <= ramValid;
          if (ramValid) outBeat <= ramBeat;
        end
      end else if (ramValid) begin
        skidValid <= 1'b1;
        skidBeat  <= ramBeat;
      end
      level <= commitPtrNext - (rdPtr + PW'(pop));
    end
  end

  assign m_axis_output.tvalid = outValid;
  assign m_axis_output.tdata  = outBeat.data;
  assign m_axis_output.tlast  = outBeat.last;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Scoreboard bench for rx_frame_buffer: frames queued when driven,
// popped and compared at each output handshake.
module tb_rx_frame_buffer;
  import bbp_rx_pkg::*;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [15:0] okCnt, dropCnt;
  logic [9:0]  level;

  rx_frame_buffer_if sIf ();
  rx_frame_buffer_if mIf ();

  rx_frame_buffer dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .s_axis_input   (sIf),
    .m_axis_output  (mIf),
    .frame_ok_cnt   (okCnt),
    .frame_drop_cnt (dropCnt),
    .level          (level)
  );

  always #5 clk = ~clk;

  int         errCnt = 0;
  int         chkCnt = 0;
  longint     cyc = 0;
  longint     tlastCyc = 0;
  longint     lastPopCyc = 0;
  int         popCnt = 0;
  int         readyMode = 1;
  rxfb_beat_t q[$];
  logic       prevStall = 1'b0;
  rxfb_beat_t prevBeat;
  rxfb_beat_t expBeat;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       mIf.tready = 1'b0;
      1:       mIf.tready = 1'b1;
      default: mIf.tready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!aresetn) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        check("holdValid", 64'(mIf.tvalid), 64'd1);
        check("holdData", mIf.tdata, prevBeat.data);
        check("holdLast", 64'(mIf.tlast), 64'(prevBeat.last));
      end
      if (mIf.tvalid && mIf.tready) begin
        check("sbPending", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          expBeat = q.pop_front();
          check("outData", mIf.tdata, expBeat.data);
          check("outLast", 64'(mIf.tlast), 64'(expBeat.last));
        end
        popCnt++;
        lastPopCyc = cyc;
      end
      prevStall     = mIf.tvalid && !mIf.tready;
      prevBeat.data = mIf.tdata;
      prevBeat.last = mIf.tlast;
    end
  end

  task automatic sendFrame(input int len, input logic [63:0] base,
                           input bit rnd, input bit keep);
    rxfb_beat_t f[$];
    for (int i = 0; i < len; i++) begin
      rxfb_beat_t b;
      b.data = rnd ? {$urandom(), $urandom()} : base + 64'(i);
      b.last = (i == len - 1);
      @(posedge clk); #1;
      sIf.tvalid = 1'b1;
      sIf.tdata  = b.data;
      sIf.tlast  = b.last;
      f.push_back(b);
    end
    tlastCyc = cyc;
    if (keep) foreach (f[j]) q.push_back(f[j]);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    sIf.tvalid = 1'b0;
    sIf.tlast  = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    aresetn    = 1'b0;
    sIf.tvalid = 1'b0;
    sIf.tlast  = 1'b0;
    sIf.tdata  = '0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(tag, 64'(q.size()), 64'd0);
    check({tag, "Idle"}, 64'(mIf.tvalid), 64'd0);
  endtask

  initial begin
    int n;
    int p0;
    int len;
    aresetn    = 1'b0;
    sIf.tvalid = 1'b0;
    sIf.tdata  = '0;
    sIf.tlast  = 1'b0;
    #12;
    check("rstTready", 64'(sIf.tready), 64'd0);
    check("rstValid", 64'(mIf.tvalid), 64'd0);
    check("rstData", mIf.tdata, 64'd0);
    check("rstLevel", 64'(level), 64'd0);
    check("rstOk", 64'(okCnt), 64'd0);
    check("rstDrop", 64'(dropCnt), 64'd0);
    @(posedge clk); #1 aresetn = 1'b1;
    check("tready", 64'(sIf.tready), 64'd1);

    // single 4-beat frame and first-beat latency
    sendFrame(4, 64'h1, 0, 1);
    idle();
    n = 0;
    while (!mIf.tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t1Latency", 64'(cyc - tlastCyc - 1), 64'd2);
    waitDrain("t1Drain");
    check("t1Ok", 64'(okCnt), 64'd1);
    check("t1Drop", 64'(dropCnt), 64'd0);

    // oversize frame dropped, following frame kept
    doReset();
    sendFrame(257, 64'h1000, 0, 0);
    sendFrame(2, 64'h2000, 0, 1);
    idle();
    waitDrain("t2Drain");
    check("t2Ok", 64'(okCnt), 64'd1);
    check("t2Drop", 64'(dropCnt), 64'd1);

    // overflow with output stalled
    doReset();
    readyMode = 0;
    sendFrame(200, 64'h10000, 0, 1);
    sendFrame(200, 64'h20000, 0, 1);
    sendFrame(200, 64'h30000, 0, 0);
    idle();
    repeat (5) @(posedge clk);
    #1;
    check("t3Level", 64'(level), 64'd400);
    check("t3Ok", 64'(okCnt), 64'd2);
    check("t3Drop", 64'(dropCnt), 64'd1);
    check("t3Head", 64'(mIf.tvalid), 64'd1);
    p0 = popCnt;
    readyMode = 1;
    waitDrain("t3Drain");
    check("t3Beats", 64'(popCnt - p0), 64'd400);
    check("t3LevelEnd", 64'(level), 64'd0);
    check("t3DropEnd", 64'(dropCnt), 64'd1);

    // back-to-back single-beat frames
    doReset();
    p0 = popCnt;
    for (int i = 0; i < 16; i++)
      sendFrame(1, 64'h4000 + 64'(i), 0, 1);
    idle();
    waitDrain("t4Drain");
    check("t4Beats", 64'(popCnt - p0), 64'd16);
    check("t4Rate", 64'(lastPopCyc - tlastCyc), 64'd3);
    check("t4Ok", 64'(okCnt), 64'd16);
    check("t4Drop", 64'(dropCnt), 64'd0);

    // random frames under random backpressure
    doReset();
    readyMode = 2;
    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, 64);
      n = 0;
      while (q.size() + len > 400 && n < 4000) begin
        @(posedge clk); #1;
        sIf.tvalid = 1'b0;
        sIf.tlast  = 1'b0;
        n++;
      end
      if (n >= 4000) check("t5Room", 64'(q.size()), 64'd0);
      sendFrame(len, 64'd0, 1, 1);
    end
    idle();
    waitDrain("t5Drain");
    check("t5Ok", 64'(okCnt), 64'd1000);
    check("t5Drop", 64'(dropCnt), 64'd0);
    readyMode = 1;

    // reset in the middle of a frame
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      sIf.tvalid = 1'b1;
      sIf.tdata  = 64'h5000 + 64'(i);
      sIf.tlast  = 1'b0;
    end
    @(posedge clk); #1;
    aresetn    = 1'b0;
    sIf.tvalid = 1'b0;
    #1;
    check("t6Valid", 64'(mIf.tvalid), 64'd0);
    check("t6Data", mIf.tdata, 64'd0);
    check("t6Last", 64'(mIf.tlast), 64'd0);
    check("t6Level", 64'(level), 64'd0);
    check("t6OkRst", 64'(okCnt), 64'd0);
    check("t6Tready", 64'(sIf.tready), 64'd0);
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    sendFrame(5, 64'h6000, 0, 1);
    idle();
    waitDrain("t6Drain");
    check("t6Ok", 64'(okCnt), 64'd1);
    check("t6Drop", 64'(dropCnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
